sf_camera_line_sequencer: RTL and testbench
===========================================

Name: sf_camera_line_sequencer

Overview:
Sequences frame capture from an already clock-domain-synchronised camera pixel stream into two ping-pong line buffers. Responsibilities:
- Arm on enable and align to VSYNC.
- Pack 8-bit pixels into 32-bit words and write one line per buffer.
- Hand full buffers to the memory-side reader and count lines against the programmed line count.
- Report capture completion and overflow.
It sits between the camera sync/pixel front end and the wishbone memory FIFO logic.

Parameters:
ADDR_WIDTH, 9, word address width of each line buffer; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- i_enable  input  1  arm capture; low forces IDLE
- i_continuous  input  1  1 = re-arm after each frame; 0 = single shot
- i_hcount  input  32  lines per frame; 0 = capture until VSYNC falls
- i_vsync  input  1  frame valid, clk domain
- i_hsync  input  1  line valid, clk domain
- i_pix_stb  input  1  one-cycle pixel strobe, clk domain
- i_pix_data  input  8  pixel byte
- o_buf_wr_stb  output  1  line buffer write strobe
- o_buf_wr_sel  output  1  target buffer (0/1)
- o_buf_wr_addr  output  ADDR_WIDTH  word address
- o_buf_wr_data  output  32  packed word
- o_rdy  output  2  buffer n full, owned by reader
- o_size0  output  ADDR_WIDTH+1  word count of buffer 0
- o_size1  output  ADDR_WIDTH+1  word count of buffer 1
- i_done  input  2  one-cycle pulse: reader releases buffer n
- o_line_count  output  32  lines seen in current frame
- o_captured  output  1  frame complete
- o_overflow  output  1  sticky: line dropped or truncated
- o_frame_error  output  1  sticky: VSYNC fell before i_hcount lines

Behaviour:
Reset:
- All outputs 0; state IDLE.
- Both buffers free; last-filled pointer = 1, so buffer 0 is chosen first.

States:
- IDLE: wait i_enable=1 -> WAIT_VSYNC. Clears o_captured, o_line_count, o_overflow, o_frame_error.
- WAIT_VSYNC: VSYNC rising edge (registered previous value) -> WAIT_LINE. A frame already in progress at arm time is skipped.
- WAIT_LINE: on HSYNC rising edge:
  - If a buffer is free, select it -> CAPTURE, address 0, byte index 0.
  - If no buffer is free, set o_overflow, increment o_line_count, stay in WAIT_LINE for the line duration.
  - VSYNC falling -> FRAME_DONE.
- CAPTURE: each i_pix_stb shifts the byte in, big-endian (first byte to [31:24]).
  - The 4th byte produces o_buf_wr_stb the next cycle, then the address increments.
  - Writes beyond 2**ADDR_WIDTH words are discarded and set o_overflow.
  - HSYNC falling -> LINE_DONE.
- LINE_DONE (1 cycle):
  - Write the partial word if byte index != 0; unused low bytes are 0.
  - Latch the size, increment o_line_count, and set o_rdy[sel] the following cycle.
  - If o_line_count reaches i_hcount (i_hcount != 0) -> FRAME_DONE; otherwise -> WAIT_LINE.
- FRAME_DONE:
  - Assert o_captured.
  - If VSYNC fell and o_line_count < i_hcount (i_hcount != 0), set o_frame_error.
  - i_continuous=1: after 1 cycle, deassert o_captured, clear o_line_count -> WAIT_VSYNC.
  - i_continuous=0: hold o_captured until i_enable=0 -> IDLE.

Buffer choice:
- Prefer the buffer not last filled if it is free; otherwise the other buffer if it is free.

Hand-off and release:
- Latency: HSYNC falling sampled at cycle t -> LINE_DONE at t+1 -> o_rdy at t+2.
- i_done[n] clears o_rdy[n] next cycle.
- i_done on a non-ready buffer is ignored.
- Release and a new hsync in the same cycle: the released buffer is not eligible until the next cycle.

i_enable low:
- Immediate return to IDLE from any state.
- The line being captured is discarded (not handed over).
- o_rdy and sizes of buffers already handed over are unchanged.

Zero-length line (HSYNC pulse with no pixels):
- Handed over with size 0; still counted.

Test Plan:
1. i_hcount=2, 4-pixel lines 01..04, 05..08, reader releases promptly -> words 0x01020304 to buf0 and 0x05060708 to buf1, sizes 1/1, o_line_count=2, o_captured=1.
2. Line of 6 pixels AA..AF -> buf0 words 0xAAABACAD and 0xAEAF0000, size 2, o_rdy[0] two cycles after HSYNC falls.
3. Reader never asserts i_done, 3 lines -> buf0 and buf1 filled, third line dropped, o_overflow=1, o_line_count=3.
4. ADDR_WIDTH=2, 20-pixel line -> 4 words written, size 4, o_overflow=1.
5. i_hcount=5, VSYNC falls after 3 lines -> o_captured=1, o_frame_error=1; with i_continuous=1, o_captured pulses 1 cycle and the next VSYNC rise starts a new frame at o_line_count=0.
6. i_enable dropped mid-line -> IDLE next cycle, no o_rdy for that line, prior o_rdy held; rst asserted mid-CAPTURE -> all outputs 0 immediately.

Source files
------------

// File: rtl/sf_camera_line_sequencer.sv
// Captures a VSYNC-aligned frame into two ping-pong line buffers of packed 32-bit words; word write 1 cycle after 4th byte, o_rdy 2 cycles after HSYNC falls.
// No stall path: a line with no free buffer is dropped and words past the buffer end are discarded, both flagged in o_overflow.
module sf_camera_line_sequencer #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_continuous,
  input  logic [31:0]           i_hcount,
  input  logic                  i_vsync,
  input  logic                  i_hsync,
  input  logic                  i_pix_stb,
  input  logic [7:0]            i_pix_data,
  output logic                  o_buf_wr_stb,
  output logic                  o_buf_wr_sel,
  output logic [ADDR_WIDTH-1:0] o_buf_wr_addr,
  output logic [31:0]           o_buf_wr_data,
  output logic [1:0]            o_rdy,
  output logic [ADDR_WIDTH:0]   o_size0,
  output logic [ADDR_WIDTH:0]   o_size1,
  input  logic [1:0]            i_done,
  output logic [31:0]           o_line_count,
  output logic                  o_captured,
  output logic                  o_overflow,
  output logic                  o_frame_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VSYNC,
    S_WAIT_LINE,
    S_CAPTURE,
    S_LINE_DONE,
    S_FRAME_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state_q, state_d;
  logic                    vsync_q, hsync_q;
  logic                    vs_rise, vs_fall, hs_rise, hs_fall;
  logic                    sel_q, last_sel_q;
  logic [1:0]              rdy_q;
  logic [ADDR_WIDTH:0]     size0_q, size1_q, word_cnt_q, size_d;
  logic [1:0]              byte_idx_q;
  logic [23:0]             shift_q;
  logic [31:0]             line_cnt_q, line_cnt_inc;
  logic                    overflow_q, frame_err_q;
  logic                    wr_stb_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [31:0]             wr_data_q, partial_dat;
  logic                    pick_vld, pick_sel, part_ok, hit_count;

  assign vs_rise      = i_vsync & ~vsync_q;
  assign vs_fall      = ~i_vsync & vsync_q;
  assign hs_rise      = i_hsync & ~hsync_q;
  assign hs_fall      = ~i_hsync & hsync_q;
  assign line_cnt_inc = line_cnt_q + 32'd1;
  assign hit_count    = (i_hcount != 32'd0) && (line_cnt_inc == i_hcount);
  assign part_ok      = (byte_idx_q != 2'd0) && (word_cnt_q != FULL);
  assign size_d       = word_cnt_q + {{ADDR_WIDTH{1'b0}}, part_ok};

  // Prefer the buffer not filled last; fall back to the other one.
  always_comb begin
    pick_vld = 1'b0;
    pick_sel = 1'b0;
    if (!rdy_q[~last_sel_q]) begin
      pick_vld = 1'b1;
      pick_sel = ~last_sel_q;
    end else if (!rdy_q[last_sel_q]) begin
      pick_vld = 1'b1;
      pick_sel = last_sel_q;
    end
  end

  // Left-align the trailing bytes of a short line, zero-filling the rest.
  always_comb begin
    partial_dat = 32'd0;
    case (byte_idx_q)
      2'd1:    partial_dat = {shift_q[7:0], 24'd0};
      2'd2:    partial_dat = {shift_q[15:0], 16'd0};
      2'd3:    partial_dat = {shift_q[23:0], 8'd0};
      default: partial_dat = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (i_enable) state_d = S_WAIT_VSYNC;
      S_WAIT_VSYNC: if (vs_rise) state_d = S_WAIT_LINE;
      S_WAIT_LINE: begin
        if (vs_fall)                  state_d = S_FRAME_DONE;
        else if (hs_rise && pick_vld) state_d = S_CAPTURE;
      end
      S_CAPTURE:    if (hs_fall) state_d = S_LINE_DONE;
      S_LINE_DONE:  state_d = hit_count ? S_FRAME_DONE : S_WAIT_LINE;
      S_FRAME_DONE: if (i_continuous) state_d = S_WAIT_VSYNC;
      default:      state_d = S_IDLE;
    endcase
    if (!i_enable) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q     <= 1'b0;
      hsync_q     <= 1'b0;
      sel_q       <= 1'b0;
      last_sel_q  <= 1'b1;
      rdy_q       <= 2'b00;
      size0_q     <= '0;
      size1_q     <= '0;
      word_cnt_q  <= '0;
      byte_idx_q  <= 2'd0;
      shift_q     <= 24'd0;
      line_cnt_q  <= 32'd0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 32'd0;
    end else begin
      vsync_q  <= i_vsync;
      hsync_q  <= i_hsync;
      wr_stb_q <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (i_done[n]) rdy_q[n] <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          line_cnt_q  <= 32'd0;
          overflow_q  <= 1'b0;
          frame_err_q <= 1'b0;
        end
        S_WAIT_LINE: if (i_enable) begin
          if (vs_fall) begin
            if ((i_hcount != 32'd0) && (line_cnt_q < i_hcount)) frame_err_q <= 1'b1;
          end else if (hs_rise) begin
            if (pick_vld) begin
              sel_q      <= pick_sel;
              word_cnt_q <= '0;
              byte_idx_q <= 2'd0;
            end else begin
              overflow_q <= 1'b1;
              line_cnt_q <= line_cnt_inc;
            end
          end
        end
        S_CAPTURE: if (i_enable && i_pix_stb) begin
          shift_q    <= {shift_q[15:0], i_pix_data};
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (word_cnt_q == FULL) begin
              overflow_q <= 1'b1;
            end else begin
              wr_stb_q   <= 1'b1;
              wr_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
              wr_data_q  <= {shift_q, i_pix_data};
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        S_LINE_DONE: if (i_enable) begin
          if (byte_idx_q != 2'd0) begin
            if (word_cnt_q == FULL) begin
              overflow_q <= 1'b1;
            end else begin
              wr_stb_q  <= 1'b1;
              wr_addr_q <= word_cnt_q[ADDR_WIDTH-1:0];
              wr_data_q <= partial_dat;
            end
          end
          if (sel_q) size1_q <= size_d;
          else       size0_q <= size_d;
          rdy_q[sel_q] <= 1'b1;
          last_sel_q   <= sel_q;
          line_cnt_q   <= line_cnt_inc;
        end
        S_FRAME_DONE: if (i_enable && i_continuous) line_cnt_q <= 32'd0;
        default: ;
      endcase
    end
  end

  assign o_buf_wr_stb  = wr_stb_q;
  assign o_buf_wr_sel  = sel_q;
  assign o_buf_wr_addr = wr_addr_q;
  assign o_buf_wr_data = wr_data_q;
  assign o_rdy         = rdy_q;
  assign o_size0       = size0_q;
  assign o_size1       = size1_q;
  assign o_line_count  = line_cnt_q;
  assign o_captured    = (state_q == S_FRAME_DONE);
  assign o_overflow    = overflow_q;
  assign o_frame_error = frame_err_q;

endmodule

// File: tb/tb_sf_camera_line_sequencer.sv
// Directed bench: a default-depth instance plus a 4-word instance share one stimulus set.
module tb_sf_camera_line_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable, i_continuous, i_vsync, i_hsync, i_pix_stb;
  logic [31:0] i_hcount;
  logic [7:0]  i_pix_data;
  logic [1:0]  i_done;

  logic        wr_stb, wr_sel, captured, overflow, frame_error;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data, line_count;
  logic [1:0]  rdy;
  logic [9:0]  size0, size1;

  logic        s_wr_stb, s_wr_sel, s_captured, s_overflow, s_frame_error;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data, s_line_count;
  logic [1:0]  s_rdy;
  logic [2:0]  s_size0, s_size1;

  int errors = 0;
  int checks = 0;

  logic [31:0] log_data[$];
  int          log_addr[$];
  logic        log_sel[$];
  logic [31:0] s_log_data[$];
  int          s_log_addr[$];

  always #5 clk = ~clk;

  sf_camera_line_sequencer dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_continuous(i_continuous),
    .i_hcount(i_hcount), .i_vsync(i_vsync), .i_hsync(i_hsync),
    .i_pix_stb(i_pix_stb), .i_pix_data(i_pix_data),
    .o_buf_wr_stb(wr_stb), .o_buf_wr_sel(wr_sel), .o_buf_wr_addr(wr_addr),
    .o_buf_wr_data(wr_data), .o_rdy(rdy), .o_size0(size0), .o_size1(size1),
    .i_done(i_done), .o_line_count(line_count), .o_captured(captured),
    .o_overflow(overflow), .o_frame_error(frame_error)
  );

  sf_camera_line_sequencer #(.ADDR_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_continuous(i_continuous),
    .i_hcount(i_hcount), .i_vsync(i_vsync), .i_hsync(i_hsync),
    .i_pix_stb(i_pix_stb), .i_pix_data(i_pix_data),
    .o_buf_wr_stb(s_wr_stb), .o_buf_wr_sel(s_wr_sel), .o_buf_wr_addr(s_wr_addr),
    .o_buf_wr_data(s_wr_data), .o_rdy(s_rdy), .o_size0(s_size0), .o_size1(s_size1),
    .i_done(i_done), .o_line_count(s_line_count), .o_captured(s_captured),
    .o_overflow(s_overflow), .o_frame_error(s_frame_error)
  );

  always @(negedge clk) begin
    if (rst && wr_stb) begin
      log_data.push_back(wr_data);
      log_addr.push_back(int'(wr_addr));
      log_sel.push_back(wr_sel);
    end
    if (rst && s_wr_stb) begin
      s_log_data.push_back(s_wr_data);
      s_log_addr.push_back(int'(s_wr_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_enable = 1'b0; i_continuous = 1'b0; i_hcount = 32'd0;
    i_vsync = 1'b0; i_hsync = 1'b0; i_pix_stb = 1'b0; i_pix_data = 8'd0; i_done = 2'b00;
    tick(); tick();
    rst = 1'b1;
    tick();
    log_data.delete(); log_addr.delete(); log_sel.delete();
    s_log_data.delete(); s_log_addr.delete();
  endtask

  task automatic arm();
    i_enable = 1'b0; i_vsync = 1'b0;
    tick(); tick();
    i_enable = 1'b1;
    tick();
    i_vsync = 1'b1;
    tick();
  endtask

  task automatic line_pixels(input int n, input logic [7:0] first);
    i_hsync = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      i_pix_stb = 1'b1;
      i_pix_data = first + 8'(i);
      tick();
    end
    i_pix_stb = 1'b0;
    i_hsync = 1'b0;
  endtask

  task automatic send_line(input int n, input logic [7:0] first);
    line_pixels(n, first);
    tick(); tick(); tick();
  endtask

  task automatic release_bufs(input logic [1:0] mask);
    i_done = mask;
    tick();
    i_done = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_enable = 1'b0; i_continuous = 1'b0; i_hcount = 32'd0;
    i_vsync = 1'b0; i_hsync = 1'b0; i_pix_stb = 1'b0; i_pix_data = 8'd0; i_done = 2'b00;
    tick(); tick();
    checks++;
    if ({wr_stb, wr_sel, wr_addr, wr_data, rdy, size0, size1, line_count, captured, overflow, frame_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b size0=%0d line_count=%0d captured=%b, all required 0", rdy, size0, line_count, captured);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_two_lines();
    do_reset();
    i_hcount = 32'd2;
    arm();
    send_line(4, 8'h01);
    release_bufs(2'b11);
    send_line(4, 8'h05);
    checks++;
    if (log_data.size() !== 2) begin
      errors++; $display("FAIL t1_write_count: got %0d required 2", log_data.size());
    end else begin
      checks++;
      if ({log_sel[0], log_addr[0], log_data[0]} !== {1'b0, 32'd0, 32'h01020304}) begin
        errors++; $display("FAIL t1_word0: sel=%b addr=%0d data=%h required 0/0/01020304", log_sel[0], log_addr[0], log_data[0]);
      end
      checks++;
      if ({log_sel[1], log_addr[1], log_data[1]} !== {1'b1, 32'd0, 32'h05060708}) begin
        errors++; $display("FAIL t1_word1: sel=%b addr=%0d data=%h required 1/0/05060708", log_sel[1], log_addr[1], log_data[1]);
      end
    end
    checks++;
    if ({size0, size1} !== {10'd1, 10'd1}) begin
      errors++; $display("FAIL t1_sizes: got %0d/%0d required 1/1", size0, size1);
    end
    checks++;
    if ({line_count, captured} !== {32'd2, 1'b1}) begin
      errors++; $display("FAIL t1_done: line_count=%0d captured=%b required 2/1", line_count, captured);
    end
    release_bufs(2'b11);
    checks++;
    if (rdy !== 2'b00) begin
      errors++; $display("FAIL t1_release: rdy=%b required 00", rdy);
    end
  endtask

  task automatic test_partial_word();
    do_reset();
    arm();
    line_pixels(6, 8'hAA);
    tick();
    checks++;
    if (rdy !== 2'b00) begin
      errors++; $display("FAIL t2_rdy_early: rdy=%b required 00 one cycle after hsync fall", rdy);
    end
    tick();
    checks++;
    if ({rdy, size0} !== {2'b01, 10'd2}) begin
      errors++; $display("FAIL t2_rdy_size: rdy=%b size0=%0d required 01/2", rdy, size0);
    end
    tick(); tick();
    checks++;
    if (log_data.size() !== 2) begin
      errors++; $display("FAIL t2_write_count: got %0d required 2", log_data.size());
    end else begin
      checks++;
      if ({log_data[0], log_data[1], log_addr[1]} !== {32'hAAABACAD, 32'hAEAF0000, 32'd1}) begin
        errors++; $display("FAIL t2_words: %h %h addr1=%0d required AAABACAD AEAF0000 1", log_data[0], log_data[1], log_addr[1]);
      end
    end
    release_bufs(2'b01);
  endtask

  task automatic test_no_release();
    do_reset();
    arm();
    send_line(4, 8'h11);
    send_line(4, 8'h21);
    send_line(4, 8'h31);
    checks++;
    if ({rdy, overflow, line_count} !== {2'b11, 1'b1, 32'd3}) begin
      errors++; $display("FAIL t3_drop: rdy=%b overflow=%b line_count=%0d required 11/1/3", rdy, overflow, line_count);
    end
    checks++;
    if (log_data.size() !== 2) begin
      errors++; $display("FAIL t3_write_count: got %0d required 2", log_data.size());
    end
    i_vsync = 1'b0;
    tick();
    checks++;
    if ({captured, frame_error} !== 2'b10) begin
      errors++; $display("FAIL t3_vsync_end: captured=%b frame_error=%b required 1/0", captured, frame_error);
    end
  endtask

  task automatic test_truncate();
    do_reset();
    arm();
    send_line(20, 8'h00);
    checks++;
    if ({s_overflow, s_size0, s_rdy} !== {1'b1, 3'd4, 2'b01}) begin
      errors++; $display("FAIL t4_small: overflow=%b size0=%0d rdy=%b required 1/4/01", s_overflow, s_size0, s_rdy);
    end
    checks++;
    if (s_log_data.size() !== 4) begin
      errors++; $display("FAIL t4_small_writes: got %0d required 4", s_log_data.size());
    end else begin
      checks++;
      if ({s_log_addr[3], s_log_data[3]} !== {32'd3, 32'h0C0D0E0F}) begin
        errors++; $display("FAIL t4_last_word: addr=%0d data=%h required 3/0C0D0E0F", s_log_addr[3], s_log_data[3]);
      end
    end
    checks++;
    if ({overflow, size0} !== {1'b0, 10'd5}) begin
      errors++; $display("FAIL t4_big: overflow=%b size0=%0d required 0/5", overflow, size0);
    end
  endtask

  task automatic test_frame_error_continuous();
    do_reset();
    i_hcount = 32'd5;
    i_continuous = 1'b1;
    arm();
    for (int l = 0; l < 3; l++) begin
      send_line(4, 8'h40);
      release_bufs(2'b11);
    end
    i_vsync = 1'b0;
    tick();
    checks++;
    if ({captured, frame_error, line_count} !== {1'b1, 1'b1, 32'd3}) begin
      errors++; $display("FAIL t5_short_frame: captured=%b frame_error=%b line_count=%0d required 1/1/3", captured, frame_error, line_count);
    end
    tick();
    checks++;
    if ({captured, line_count} !== {1'b0, 32'd0}) begin
      errors++; $display("FAIL t5_rearm: captured=%b line_count=%0d required 0/0", captured, line_count);
    end
    i_vsync = 1'b1;
    tick();
    send_line(4, 8'h50);
    release_bufs(2'b11);
    checks++;
    if ({line_count, frame_error, captured} !== {32'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL t5_next_frame: line_count=%0d frame_error=%b captured=%b required 1/1/0", line_count, frame_error, captured);
    end
  endtask

  task automatic test_enable_drop_and_reset();
    do_reset();
    arm();
    send_line(4, 8'h10);
    i_hsync = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      i_pix_stb = 1'b1; i_pix_data = 8'h20 + 8'(i);
      tick();
    end
    i_pix_stb = 1'b0;
    i_enable = 1'b0;
    tick();
    i_hsync = 1'b0;
    tick(); tick();
    checks++;
    if ({rdy, size0, size1, line_count, captured} !== {2'b01, 10'd1, 10'd0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL t6_enable_drop: rdy=%b size0=%0d size1=%0d line_count=%0d captured=%b required 01/1/0/0/0", rdy, size0, size1, line_count, captured);
    end
    checks++;
    if (log_data.size() !== 1) begin
      errors++; $display("FAIL t6_write_count: got %0d required 1", log_data.size());
    end
    release_bufs(2'b10);
    checks++;
    if (rdy !== 2'b01) begin
      errors++; $display("FAIL t6_done_ignored: rdy=%b required 01", rdy);
    end
    arm();
    i_hsync = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      i_pix_stb = 1'b1; i_pix_data = 8'h30 + 8'(i);
      tick();
    end
    i_pix_stb = 1'b0;
    checks++;
    if ({wr_stb, wr_sel, wr_data} !== {1'b1, 1'b1, 32'h30313233}) begin
      errors++; $display("FAIL t6_precond: wr_stb=%b sel=%b data=%h required 1/1/30313233", wr_stb, wr_sel, wr_data);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wr_stb, wr_sel, wr_addr, wr_data, rdy, size0, size1, line_count, captured, overflow, frame_error} !== '0) begin
      errors++; $display("FAIL t6_async_reset: wr_stb=%b rdy=%b size0=%0d data=%h, all required 0", wr_stb, rdy, size0, wr_data);
    end
    i_hsync = 1'b0;
    i_enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_partial_word();
    test_no_release();
    test_truncate();
    test_frame_error_continuous();
    test_enable_drop_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
